// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
//  Shared types and constants for the PWM capture block.
//  cap_state_t : capture FSM state (IDLE / ARM / MEAS)
//  SYNC_N_MIN  : smallest synchroniser depth that is safe for an async input
// ----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // capture disabled, counters held at 0
      ARM  = 2'd1,   // enabled, waiting for the first rising edge
      MEAS = 2'd2    // reference edge seen, every further rise is a measurement
   } cap_state_t;

   localparam int SYNC_N_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
//  Plain N-flop synchroniser for a single asynchronous bit.
//  Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous reset, active low (all flops cleared to 0)
//   d     in  asynchronous input
//   q     out synchronised output, N clk cycles behind d
// ----------------------------------------------------------------------------
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] sr_q;
   logic [N-1:0] sr_d;

   always_comb begin
      sr_d = {sr_q[N-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q = sr_q[N-1];

endmodule

// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture
//  Receive side of the PWM generator: measures period (rise to rise) and high
//  time of an asynchronous PWM input, in clk cycles. per/thr use the same
//  format as the generator's inputs so a captured waveform can be replayed.
//  Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous reset, active low
//   en        in   capture enable
//   pwm_in    in   PWM input, asynchronous to clk
//   clr_ovf   in   single-cycle pulse clearing the sticky ovf flag
//   per       out  last measured period
//   thr       out  last measured high time
//   meas_vld  out  1-cycle pulse, per/thr updated this cycle
//   ovf       out  sticky: no rising edge within 2**W-1 cycles
//   lvl       out  synchronised pwm_in level
//   dbg_state out  current capture FSM state
//  Handshake: meas_vld is a pure strobe with no ready; per/thr are registers
//  that stay valid until the next strobe, so a consumer may sample them at
//  any time and will never see a torn pair.
// ----------------------------------------------------------------------------
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int W      = 8,
   parameter int SYNC_N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         pwm_in,
   input  logic         clr_ovf,
   output logic [W-1:0] per,
   output logic [W-1:0] thr,
   output logic         meas_vld,
   output logic         ovf,
   output logic         lvl,
   output cap_state_t   dbg_state
);

   // A depth below the safe minimum is silently raised rather than trusted.
   localparam int SYNC_EFF = (SYNC_N < SYNC_N_MIN) ? SYNC_N_MIN : SYNC_N;
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic         pwm_s;
   logic         pwm_q,      pwm_d;
   logic         rise;
   logic         timeout;

   cap_state_t   state_q,    state_d;
   logic [W-1:0] cyc_cnt_q,  cyc_cnt_d;
   logic [W-1:0] hi_cnt_q,   hi_cnt_d;
   logic [W-1:0] per_q,      per_d;
   logic [W-1:0] thr_q,      thr_d;
   logic         meas_vld_q, meas_vld_d;
   logic         ovf_q,      ovf_d;

   sync_ff #(.N(SYNC_EFF)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pwm_in),
      .q     (pwm_s)
   );

   assign pwm_d = pwm_s;
   assign rise  = pwm_s & ~pwm_q;

   always_comb begin
      state_d    = state_q;
      cyc_cnt_d  = cyc_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      per_d      = per_q;
      thr_d      = thr_q;
      meas_vld_d = 1'b0;
      timeout    = 1'b0;

      if (!en) begin
         // Disable overrides everything, including a coinciding rise or
         // timeout: the partial period is dropped and per/thr are kept.
         state_d   = IDLE;
         cyc_cnt_d = '0;
         hi_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cyc_cnt_d = '0;
               hi_cnt_d  = '0;
               state_d   = ARM;
            end
            ARM, MEAS: begin
               if (rise) begin
                  // The rise cycle itself is the first cycle of the new
                  // period and is always high, hence both restart at 1.
                  cyc_cnt_d = CNT_ONE;
                  hi_cnt_d  = CNT_ONE;
                  state_d   = MEAS;
                  if (state_q == MEAS) begin
                     per_d      = cyc_cnt_q;
                     thr_d      = hi_cnt_q;
                     meas_vld_d = 1'b1;
                  end
               end else if (cyc_cnt_q == CNT_MAX) begin
                  // Stuck input (0 % or 100 % duty, or too long a period):
                  // flag it and re-arm so the next two rises measure again.
                  timeout   = 1'b1;
                  cyc_cnt_d = '0;
                  hi_cnt_d  = '0;
                  state_d   = ARM;
               end else begin
                  cyc_cnt_d = cyc_cnt_q + CNT_ONE;
                  hi_cnt_d  = (hi_cnt_q == CNT_MAX) ? CNT_MAX
                            : hi_cnt_q + {{(W-1){1'b0}}, pwm_s};
               end
            end
            default: begin
               state_d   = IDLE;
               cyc_cnt_d = '0;
               hi_cnt_d  = '0;
            end
         endcase
      end

      // Set has priority over clear so a timeout is never lost.
      if (timeout) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pwm_q      <= 1'b0;
         cyc_cnt_q  <= '0;
         hi_cnt_q   <= '0;
         per_q      <= '0;
         thr_q      <= '0;
         meas_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwm_q      <= pwm_d;
         cyc_cnt_q  <= cyc_cnt_d;
         hi_cnt_q   <= hi_cnt_d;
         per_q      <= per_d;
         thr_q      <= thr_d;
         meas_vld_q <= meas_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   assign per       = per_q;
   assign thr       = thr_q;
   assign meas_vld  = meas_vld_q;
   assign ovf       = ovf_q;
   assign lvl       = pwm_s;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// ----------------------------------------------------------------------------
// tb_pwm_capture
//  Self-checking bench for pwm_capture. The reference model works on cycle
//  timestamps: it records every driven pwm_in sample, derives the
//  synchronised level and rising edges from that history, and computes
//  per/thr as timestamp differences and sums of high samples.
// ----------------------------------------------------------------------------
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int W       = 8;
   localparam int SYNC_N  = 2;
   localparam int CNT_MAX = (1 << W) - 1;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic         en      = 1'b0;
   logic         pwm_in  = 1'b0;
   logic         clr_ovf = 1'b0;
   logic [W-1:0] per;
   logic [W-1:0] thr;
   logic         meas_vld;
   logic         ovf;
   logic         lvl;
   cap_state_t   dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   pwm_capture #(.W(W), .SYNC_N(SYNC_N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .clr_ovf   (clr_ovf),
      .per       (per),
      .thr       (thr),
      .meas_vld  (meas_vld),
      .ovf       (ovf),
      .lvl       (lvl),
      .dbg_state (dbg_state)
   );

   // ---------------- reference model ----------------
   bit           pin_h [0:8191];   // pwm_in driven in each cycle since reset
   int           m_t;              // index of the next cycle to be driven
   bit           m_act;            // enabled for at least one full cycle
   int           m_ref;            // cycle of the reference rise, -1 if none
   int           m_base;           // cycle at which the timeout count was 0
   logic [W-1:0] m_per;
   logic [W-1:0] m_thr;
   logic         m_vld;
   logic         m_ovf;
   logic [20:0]  exp_vec;
   logic [20:0]  obs_vec;

   assign obs_vec = {dbg_state, lvl, ovf, meas_vld, per, thr};

   // Synchronised level seen inside cycle t.
   function automatic bit ps(input int t);
      return (t >= SYNC_N) ? pin_h[t-SYNC_N] : 1'b0;
   endfunction

   function automatic cap_state_t m_state();
      if (!m_act) return IDLE;
      if (m_ref >= 0) return MEAS;
      return ARM;
   endfunction

   task automatic model_reset();
      m_t = 0; m_act = 1'b0; m_ref = -1; m_base = 0;
      m_per = '0; m_thr = '0; m_vld = 1'b0; m_ovf = 1'b0;
      exp_vec = '0;
   endtask

   // Drive one cycle of inputs, advance the model, and stop at the next
   // falling edge with exp_vec describing what the DUT should show.
   task automatic step(input bit e, input bit p, input bit c);
      bit r;
      bit to;
      int t;
      int s;
      en = e; pwm_in = p; clr_ovf = c;
      t = m_t;
      pin_h[t] = p;
      r = ps(t) & ~ps(t-1);
      to = 1'b0;
      m_vld = 1'b0;
      if (!e) begin
         m_act = 1'b0; m_ref = -1;
      end else if (!m_act) begin
         m_act = 1'b1; m_ref = -1; m_base = t + 1;
      end else if (r) begin
         if (m_ref >= 0) begin
            s = 0;
            for (int k = m_ref; k < t; k++) s += int'(ps(k));
            m_per = W'(t - m_ref);
            m_thr = W'(s);
            m_vld = 1'b1;
         end
         m_ref = t; m_base = t;
      end else if (t - m_base == CNT_MAX) begin
         to = 1'b1; m_ref = -1; m_base = t + 1;
      end
      if (to) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      m_t = t + 1;
      exp_vec = {m_state(), ps(m_t), m_ovf, m_vld, m_per, m_thr};
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_por();
      rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; clr_ovf = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (obs_vec !== '0) begin
         n_miss++; $display("FAIL por got %h expected %h", obs_vec, 21'h0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fixed_pwm();
      int n_v = 0; int last_t = -1; int bad_gap = 0;
      logic [W-1:0] fp = '0; logic [W-1:0] ft = '0;
      repeat (3) begin
         step(0, 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL fixed_idle t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      for (int p = 0; p < 7; p++) begin
         for (int k = 0; k < 8; k++) begin
            step(1, k < 3, 0); n_vec++;
            if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL fixed_pwm t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
            if (meas_vld) begin
               if (n_v == 0) begin fp = per; ft = thr; end
               else if (m_t - last_t != 8) bad_gap++;
               n_v++; last_t = m_t;
            end
         end
      end
      n_vec++;
      if (n_v != 6) begin n_miss++; $display("FAIL fixed_count got %0d expected 6", n_v); end
      n_vec++;
      if (fp !== 8'd8 || ft !== 8'd3) begin n_miss++; $display("FAIL fixed_first per=%0d thr=%0d expected 8/3", fp, ft); end
      n_vec++;
      if (bad_gap != 0) begin n_miss++; $display("FAIL fixed_spacing got %0d bad gaps expected 0", bad_gap); end
   endtask

   task automatic test_alternate();
      int n_v = 0; int n_bad = 0;
      repeat (2) begin
         step(0, 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL alt_idle t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      for (int k = 0; k < 40; k++) begin
         step(1, (k % 2) == 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL alternate t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) begin
            n_v++;
            if (per !== 8'd2 || thr !== 8'd1) n_bad++;
         end
      end
      n_vec++;
      if (n_v != 18 || n_bad != 0) begin n_miss++; $display("FAIL alt_min_period got %0d pulses %0d wrong expected 18 pulses 0 wrong", n_v, n_bad); end
   endtask

   task automatic test_timeout();
      int t_vld = -1; int t_ovf = -1; int n_hold = 0; int n_after = 0;
      repeat (2) begin
         step(0, 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL to_idle t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      for (int k = 0; k < 24; k++) begin
         step(1, (k % 8) < 3, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL to_pre t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      for (int k = 0; k < 300; k++) begin
         step(1, 1, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL to_hold t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) begin n_hold++; t_vld = m_t; end
         if (ovf && t_ovf < 0) t_ovf = m_t;
      end
      n_vec++;
      if (t_ovf - t_vld != 255) begin n_miss++; $display("FAIL to_delay got %0d cycles expected 255", t_ovf - t_vld); end
      n_vec++;
      if (lvl !== 1'b1 || ovf !== 1'b1 || n_hold != 1) begin n_miss++; $display("FAIL to_stuck lvl=%b ovf=%b pulses=%0d expected 1 1 1", lvl, ovf, n_hold); end
      for (int k = 0; k < 28; k++) begin
         step(1, (k >= 4) && (((k - 4) % 8) < 3), 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL to_after t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) n_after++;
      end
      n_vec++;
      if (n_after != 2) begin n_miss++; $display("FAIL to_rearm got %0d pulses expected 2", n_after); end
   endtask

   task automatic test_en_drop();
      int vt[$];
      repeat (2) begin
         step(0, 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL drop_idle t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      for (int k = 0; k < 48; k++) begin
         step(k != 21, (k % 6) < 2, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL en_drop t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) vt.push_back(m_t);
      end
      n_vec++;
      if (vt.size() != 6) begin n_miss++; $display("FAIL drop_count got %0d expected 6", vt.size()); end
      else begin
         n_vec++;
         if (vt[3] - vt[2] != 12) begin n_miss++; $display("FAIL drop_gap got %0d expected 12", vt[3] - vt[2]); end
      end
   endtask

   task automatic test_clr_ovf();
      int guard = 0;
      step(0, 0, 1); n_vec++;
      if (ovf !== 1'b0) begin n_miss++; $display("FAIL clr_alone got ovf=%b expected 0", ovf); end
      step(1, 0, 0);
      while (!(m_act && m_t == m_base + CNT_MAX) && guard < 600) begin
         step(1, 0, 0); n_vec++; guard++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL clr_wait t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      n_vec++;
      if (guard >= 600) begin n_miss++; $display("FAIL clr_bound got %0d cycles expected under 600", guard); end
      step(1, 0, 1); n_vec++;
      if (ovf !== 1'b1) begin n_miss++; $display("FAIL clr_vs_set got ovf=%b expected 1", ovf); end
      step(1, 0, 1); n_vec++;
      if (ovf !== 1'b0) begin n_miss++; $display("FAIL clr_after got ovf=%b expected 0", ovf); end
   endtask

   task automatic test_long_period();
      int n1 = 0; int n2 = 0;
      logic [W-1:0] lp = '0; logic [W-1:0] lt = '0;
      repeat (2) step(0, 0, 0);
      for (int k = 0; k < 3 * 255; k++) begin
         step(1, (k % 255) == 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL long255 t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) begin n1++; lp = per; lt = thr; end
      end
      n_vec++;
      if (n1 != 2 || lp !== 8'd255 || lt !== 8'd1 || ovf !== 1'b0) begin
         n_miss++; $display("FAIL long_max pulses=%0d per=%0d thr=%0d ovf=%b expected 2 255 1 0", n1, lp, lt, ovf);
      end
      for (int k = 0; k < 2 * 256; k++) begin
         step(1, (k % 256) == 0, 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL long256 t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         if (meas_vld) n2++;
      end
      n_vec++;
      if (n2 != 1 || ovf !== 1'b1) begin n_miss++; $display("FAIL long_over pulses=%0d ovf=%b expected 1 1", n2, ovf); end
   endtask

   task automatic test_reset_midrun();
      for (int k = 0; k < 10; k++) begin
         step(1, 1'($urandom_range(0, 1)), 0); n_vec++;
         if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL pre_rst t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
      end
      #2;
      rst_n = 1'b0; en = 1'b1; pwm_in = 1'b1; clr_ovf = 1'b0;
      #1;
      n_vec++;
      if (obs_vec !== '0) begin n_miss++; $display("FAIL rst_async got %h expected %h", obs_vec, 21'h0); end
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (obs_vec !== '0) begin n_miss++; $display("FAIL rst_hold got %h expected %h", obs_vec, 21'h0); end
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int n = 0; int hi; int lo;
      bit e; bit c;
      while (n < 1800) begin
         hi = $urandom_range(1, 6);
         lo = ($urandom_range(0, 19) == 0) ? $urandom_range(248, 258) : $urandom_range(1, 6);
         for (int k = 0; k < hi + lo; k++) begin
            e = ($urandom_range(0, 99) != 0);
            c = ($urandom_range(0, 49) == 0);
            step(e, k < hi, c); n_vec++; n++;
            if (obs_vec !== exp_vec) begin n_miss++; $display("FAIL random t=%0d got %h expected %h", m_t, obs_vec, exp_vec); end
         end
      end
   endtask

   initial begin
      test_por();
      test_fixed_pwm();
      test_alternate();
      test_timeout();
      test_en_drop();
      test_clr_ovf();
      test_long_period();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
